// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer
//   Round-robin arbiter for four requesters. It drives the select (A) and
//   enable (E) of a 2-to-4 enable decoder, so that at most one decoder line
//   is active at a time. Each grant is held until the grantee releases it.
//   After a release, E stays low for GAP_CYCLES cycles. Then the arbiter
//   re-arbitrates, starting its search after the last grantee.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   REQ[3:0] request vector, bit i = requester i
//   DONE     current grantee finished (only looked at while granting)
//   A[1:0]   granted index (decoder select), registered
//   E        grant valid (decoder enable), registered
//   TIMEOUT  one-cycle pulse on a forced release, registered
//
// Build option
//   RR_TIMEOUT_EN  when defined, a grant is forcibly released after MAX_HOLD
//                  cycles and TIMEOUT pulses as E falls. When undefined,
//                  TIMEOUT is tied low and no hold counter exists.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant, waiting for any request
// GRANT   | E high, A owned by one requester until release
// GAP     | E low for GAP_CYCLES cycles, then re-arbitrate or go idle

module rr_grant_sequencer #(
   parameter int GAP_CYCLES = 1,
   parameter int MAX_HOLD   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] REQ,
   input  logic       DONE,
   output logic [1:0] A,
   output logic       E,
   output logic       TIMEOUT
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Elaboration-time range checks. These blocks are empty for legal values.
   if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
      $error("rr_grant_sequencer: GAP_CYCLES out of range 1..15");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_grant_sequencer: MAX_HOLD out of range 2..255");
   end

   // The gap counter is a down-counter. The gap ends at its terminal count of 0.
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] a_q, a_d;
   logic       e_q, e_d;
   logic [3:0] gap_q, gap_d;

   logic       win_found;
   logic [1:0] win_idx;
   logic       release_req;
   logic       hold_tc;

`ifdef RR_TIMEOUT_EN
   // The hold counter is a down-counter loaded with MAX_HOLD-1 at grant.
   // It reaches 0 on the MAX_HOLD-th cycle of the grant.
   localparam logic [7:0] HOLD_LOAD = 8'(MAX_HOLD - 1);
   logic [7:0] hold_q, hold_d;
   logic       timeout_q, timeout_d;
`endif

   // Search ptr, ptr+1, ptr+2, ptr+3. The loop runs from the highest offset
   // down, so the nearest set bit is the last one written and therefore wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (REQ[ptr_q + 2'(k)]) begin
            win_found = 1'b1;
            win_idx   = ptr_q + 2'(k);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      e_d         = e_q;
      gap_d       = gap_q;
      release_req = DONE | ~REQ[a_q];
`ifdef RR_TIMEOUT_EN
      hold_d      = hold_q;
      timeout_d   = 1'b0;
      hold_tc     = (hold_q == 8'd0);
`else
      hold_tc     = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               a_d     = win_idx;
               e_d     = 1'b1;
               state_d = ST_GRANT;
`ifdef RR_TIMEOUT_EN
               hold_d  = HOLD_LOAD;
`endif
            end
         end

         ST_GRANT: begin
`ifdef RR_TIMEOUT_EN
            if (!hold_tc) begin
               hold_d = hold_q - 8'd1;
            end
`endif
            if (release_req || hold_tc) begin
               e_d     = 1'b0;
               ptr_d   = a_q + 2'd1;
               gap_d   = GAP_LOAD;
               state_d = ST_GAP;
`ifdef RR_TIMEOUT_EN
               // A user release on the same edge takes precedence, so no pulse.
               timeout_d = hold_tc & ~release_req;
`endif
            end
         end

         ST_GAP: begin
            if (gap_q == 4'd0) begin
               if (win_found) begin
                  a_d     = win_idx;
                  e_d     = 1'b1;
                  state_d = ST_GRANT;
`ifdef RR_TIMEOUT_EN
                  hold_d  = HOLD_LOAD;
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            e_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         a_q     <= 2'd0;
         e_q     <= 1'b0;
         gap_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         e_q     <= e_d;
         gap_q   <= gap_d;
      end
   end

`ifdef RR_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign TIMEOUT = timeout_q;
`else
   assign TIMEOUT = 1'b0;
`endif

   assign A = a_q;
   assign E = e_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
module tb_rr_grant_sequencer;

   localparam int GAP  = 1;
   localparam int MAXH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] REQ;
   logic       DONE;
   logic [1:0] A;
   logic       E;
   logic       TIMEOUT;

   always #5 clk = ~clk;

   rr_grant_sequencer #(.GAP_CYCLES(GAP), .MAX_HOLD(MAXH)) dut (
      .clk     (clk),
      .rst     (rst),
      .REQ     (REQ),
      .DONE    (DONE),
      .A       (A),
      .E       (E),
      .TIMEOUT (TIMEOUT)
   );

   // One expected grant: index, E-high length, TIMEOUT at the falling edge of E,
   // and the E-low cycles before the grant (-1 means not checked).
   typedef struct {
      int a;
      int len;
      int to;
      int gap;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic expect_grant(input int a, input int len, input int to, input int gap);
      exp_t e;
      e.a   = a;
      e.len = len;
      e.to  = to;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic wait_e(input logic val);
      int n;
      n = 0;
      while (E !== val && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (E !== val) begin
         checks++;
         failures++;
         $display("FAIL wait_e actual=%0b required=%0b (timed out)", E, val);
      end
   endtask

   // Wait for a grant, hold it for len cycles, and release it with DONE on the last cycle.
   task automatic grant_done(input int len);
      wait_e(1'b1);
      repeat (len - 1) @(negedge clk);
      DONE = 1'b1;
      @(negedge clk);
      DONE = 1'b0;
   endtask

   // Monitor: measures every grant and compares it with the next expected one.
   initial begin : monitor
      logic       in_g;
      logic [1:0] cur_a;
      int         len;
      int         low;
      int         gap_meas;
      exp_t       e;
      in_g     = 1'b0;
      cur_a    = 2'd0;
      len      = 0;
      low      = 0;
      gap_meas = 0;
      forever begin
         @(posedge clk);
         #1;
         if (E === 1'b1) begin
            if (!in_g) begin
               in_g     = 1'b1;
               cur_a    = A;
               len      = 1;
               gap_meas = low;
            end else begin
               len++;
               check("a_stable", 32'(A), 32'(cur_a));
            end
         end else begin
            if (in_g) begin
               in_g = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_grant actual_a=%0d actual_len=%0d required=none", cur_a, len);
               end else begin
                  e = exp_q.pop_front();
                  check("grant_a", 32'(cur_a), e.a);
                  check("grant_len", len, e.len);
                  check("timeout_at_fall", 32'(TIMEOUT), e.to);
                  if (e.gap >= 0) check("gap_len", gap_meas, e.gap);
               end
               low = 0;
            end
            low++;
         end
      end
   end

   initial begin : stim
      rst  = 1'b1;
      REQ  = 4'b0000;
      DONE = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_a", 32'(A), 0);
      check("reset_e", 32'(E), 0);
      check("reset_timeout", 32'(TIMEOUT), 0);
      rst = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_quiet", 32'({A, E, TIMEOUT}), 0);
      end

      // Single requester 1, DONE on the 4th grant cycle; ptr becomes 2.
      expect_grant(1, 4, 0, -1);
      REQ = 4'b0010;
      grant_done(4);
      REQ = 4'b0000;
      @(negedge clk);

      // With ptr=2, 0111 -> 2. Then ptr=3, 0101 -> 0 (wrap). Then ptr=1 -> 2.
      expect_grant(2, 1, 0, -1);
      expect_grant(0, 3, 0, GAP);
      expect_grant(2, 2, 0, GAP);
      REQ = 4'b0111;
      grant_done(1);
      REQ = 4'b0101;
      grant_done(3);
      grant_done(2);
      REQ = 4'b0000;
      @(negedge clk);

      // DONE and a withdrawn request on the same edge give a single release.
      // The second grant is released by withdrawal alone.
      expect_grant(3, 2, 0, -1);
      expect_grant(3, 1, 0, GAP);
      REQ = 4'b1000;
      wait_e(1'b1);
      @(negedge clk);
      DONE = 1'b1;
      REQ  = 4'b0000;
      @(negedge clk);
      DONE = 1'b0;
      REQ  = 4'b1000;
      wait_e(1'b1);
      REQ = 4'b0000;
      @(negedge clk);
      @(negedge clk);

`ifdef RR_TIMEOUT_EN
      // Forced release after MAX_HOLD cycles, then a re-grant after the gap.
      expect_grant(2, MAXH, 1, -1);
      expect_grant(2, 1, 0, GAP);
      REQ = 4'b0100;
      wait_e(1'b1);
      wait_e(1'b0);
      wait_e(1'b1);
      DONE = 1'b1;
      @(negedge clk);
      DONE = 1'b0;
      REQ  = 4'b0000;
      @(negedge clk);
      @(negedge clk);
`endif

      // Asynchronous reset during a grant drops E before the next clock edge.
      expect_grant(0, 1, 0, -1);
      REQ = 4'b0001;
      wait_e(1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_e", 32'(E), 0);
      check("async_rst_a", 32'(A), 0);
      REQ = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // All four requesting: order 0,1,2,3,0 with a one-cycle gap between grants.
      expect_grant(0, 2, 0, -1);
      expect_grant(1, 2, 0, GAP);
      expect_grant(2, 2, 0, GAP);
      expect_grant(3, 2, 0, GAP);
      expect_grant(0, 2, 0, GAP);
      REQ = 4'b1111;
      for (int g = 0; g < 5; g++) grant_done(2);
      REQ = 4'b0000;

      repeat (6) @(negedge clk);
      check("pending_expectations", exp_q.size(), 0);
      check("final_idle", 32'({E, TIMEOUT}), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
